// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter sharing one scoreboard write-back port among FUs
module wb_port_arbiter #(
  parameter int NR_REQ = 4,
  parameter int DATA_W = 64,
  parameter int TID_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  logic [NR_REQ*TID_W-1:0]  req_trans_id_i,
  input  logic [NR_REQ*DATA_W-1:0] req_data_i,
  input  logic [NR_REQ-1:0]        req_ex_valid_i,
  input  logic [NR_REQ*64-1:0]     req_ex_cause_i,
  output logic                     wb_valid_o,
  output logic [TID_W-1:0]         wb_trans_id_o,
  output logic [DATA_W-1:0]        wb_data_o,
  output logic                     wb_ex_valid_o,
  output logic [63:0]              wb_ex_cause_o,
  input  logic                     clr_cnt_i,
  output logic [CNT_W-1:0]         conflict_cnt_o
);

  localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    cand;
  logic              gnt_any;
  logic [NR_REQ-1:0] gnt_oh;
  logic [TID_W-1:0]  sel_tid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ex_valid;
  logic [63:0]       sel_ex_cause;
  logic              multi_req;
  logic [CNT_W-1:0]  cnt_q;

  // Search starts at rr_ptr and wraps; the modulo is explicit so non-power-of-two NR_REQ works.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NR_REQ)) cand = cand - (PTR_W+1)'(NR_REQ);
      if (!gnt_any && req_valid_i[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
    if (flush_i || !rst_ni) gnt_any = 1'b0;
  end

  always_comb begin
    gnt_oh       = '0;
    sel_tid      = '0;
    sel_data     = '0;
    sel_ex_valid = 1'b0;
    sel_ex_cause = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      gnt_oh[k] = gnt_any && (gnt_idx == PTR_W'(k));
      if (gnt_oh[k]) begin
        sel_tid      = req_trans_id_i[k*TID_W +: TID_W];
        sel_data     = req_data_i[k*DATA_W +: DATA_W];
        sel_ex_valid = req_ex_valid_i[k];
        sel_ex_cause = req_ex_cause_i[k*64 +: 64];
      end
    end
  end

  assign req_ready_o = gnt_oh;
  assign multi_req   = |(req_valid_i & (req_valid_i - NR_REQ'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_trans_id_o <= '0;
      wb_data_o     <= '0;
      wb_ex_valid_o <= 1'b0;
      wb_ex_cause_o <= '0;
      rr_ptr_q      <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
      rr_ptr_q   <= '0;
    end else if (gnt_any) begin
      wb_valid_o    <= 1'b1;
      wb_trans_id_o <= sel_tid;
      wb_data_o     <= sel_data;
      wb_ex_valid_o <= sel_ex_valid;
      wb_ex_cause_o <= sel_ex_cause;
      rr_ptr_q      <= (gnt_idx == PTR_W'(NR_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
    end else begin
      wb_valid_o <= 1'b0;
    end
  end

  // Clear wins over a simultaneous conflict; flush cycles are not counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (multi_req && !flush_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule
